// File: rtl/spi_fram_target.sv
// rtl/spi_fram_target.sv - SPI mode-0 FRAM target (WREN/WRDI/RDSR/READ/WRITE) over an internal byte array
module spi_fram_target #(
    parameter int ADDR_BYTES = 3,
    parameter int MEM_AW     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              n_ss,
    input  logic              sclk,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic              ld_we,
    input  logic [MEM_AW-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              busy
);
    localparam logic [7:0] ADDR_LAST = 8'(ADDR_BYTES - 1);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, RDATA, WDATA, STATUS, IGNORE} state_t;
    state_t state, state_nxt;

    logic [1:0]        n_ss_sync, sclk_sync, mosi_sync;
    logic              sclk_d, armed;
    logic              ss_n, sclk_rise, sclk_fall, byte_done;
    logic [2:0]        bit_cnt;
    logic [7:0]        rx_sr, rx_byte, out_sr, tx_byte, addr_cnt, status;
    logic              load_pend, is_read, wel, pend_set, pend_clr, wr_op;
    logic [MEM_AW-1:0] addr, addr_shift, addr_inc;
    logic [7:0]        mem [2**MEM_AW];
    logic              mem_we;
    logic [MEM_AW-1:0] mem_wa;
    logic [7:0]        mem_wd;

    assign ss_n       = n_ss_sync[1];
    assign sclk_rise  = sclk_sync[1] & ~sclk_d;
    assign sclk_fall  = ~sclk_sync[1] & sclk_d;
    assign rx_byte    = {rx_sr[6:0], mosi_sync[1]};
    assign byte_done  = sclk_rise & (bit_cnt == 3'd7) & (state != IDLE) & ~ss_n;
    assign addr_shift = MEM_AW'({addr, rx_byte});
    assign addr_inc   = addr + 1'b1;
    assign status     = {6'b0, wel, 1'b0};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == IDLE) begin
            if (armed && !ss_n) state_nxt = CMD;
        end else if (ss_n) begin
            state_nxt = IDLE;
        end else if (byte_done) begin
            case (state)
                CMD: begin
                    case (rx_byte)
                        8'h05:        state_nxt = STATUS;
                        8'h03, 8'h02: state_nxt = ADDR;
                        default:      state_nxt = IGNORE;
                    endcase
                end
                ADDR:    if (addr_cnt == ADDR_LAST) state_nxt = is_read ? RDATA : WDATA;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        miso_oe = (state != IDLE);
        busy    = (state != IDLE);
        miso    = ((state == RDATA) || (state == STATUS)) & out_sr[7];
    end

    // n_ss sync resets to "selected" so a select cannot be seen until n_ss is observed high
    always_ff @(posedge clk) begin
        if (rst) begin
            n_ss_sync <= 2'b00;
            sclk_sync <= 2'b00;
            mosi_sync <= 2'b00;
            sclk_d    <= 1'b0;
            armed     <= 1'b0;
            bit_cnt   <= 3'd0;
            rx_sr     <= 8'h00;
            out_sr    <= 8'h00;
            tx_byte   <= 8'h00;
            load_pend <= 1'b0;
            addr_cnt  <= 8'd0;
            addr      <= '0;
            is_read   <= 1'b0;
            wel       <= 1'b0;
            pend_set  <= 1'b0;
            pend_clr  <= 1'b0;
            wr_op     <= 1'b0;
        end else begin
            n_ss_sync <= {n_ss_sync[0], n_ss};
            sclk_sync <= {sclk_sync[0], sclk};
            mosi_sync <= {mosi_sync[0], mosi};
            sclk_d    <= sclk_sync[1];
            if (ss_n) armed <= 1'b1;
            if (state == IDLE) begin
                bit_cnt   <= 3'd0;
                rx_sr     <= 8'h00;
                out_sr    <= 8'h00;
                load_pend <= 1'b0;
                addr_cnt  <= 8'd0;
                pend_set  <= 1'b0;
                pend_clr  <= 1'b0;
                wr_op     <= 1'b0;
            end else if (ss_n) begin
                if (pend_set) wel <= 1'b1;
                if (pend_clr || wr_op) wel <= 1'b0;
            end else begin
                if (sclk_rise) begin
                    rx_sr   <= rx_byte;
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (sclk_fall) begin
                    if (load_pend) begin
                        out_sr    <= tx_byte;
                        load_pend <= 1'b0;
                    end else begin
                        out_sr <= {out_sr[6:0], 1'b0};
                    end
                end
                if (byte_done) begin
                    load_pend <= 1'b1;
                    case (state)
                        CMD: begin
                            addr_cnt <= 8'd0;
                            case (rx_byte)
                                8'h06: begin pend_set <= 1'b1; pend_clr <= 1'b0; end
                                8'h04: begin pend_set <= 1'b0; pend_clr <= 1'b1; end
                                8'h05: tx_byte <= status;
                                8'h03: is_read <= 1'b1;
                                8'h02: begin is_read <= 1'b0; wr_op <= 1'b1; end
                                default: ;
                            endcase
                        end
                        ADDR: begin
                            addr     <= addr_shift;
                            addr_cnt <= addr_cnt + 8'd1;
                            if (addr_cnt == ADDR_LAST && is_read) tx_byte <= mem[addr_shift];
                        end
                        RDATA: begin
                            addr    <= addr_inc;
                            tx_byte <= mem[addr_inc];
                        end
                        WDATA:   addr <= addr_inc;
                        STATUS:  tx_byte <= status;
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        mem_we = 1'b0;
        mem_wa = ld_addr;
        mem_wd = ld_data;
        if (byte_done && state == WDATA) begin
            mem_we = wel;
            mem_wa = addr;
            mem_wd = rx_byte;
        end else if (ld_we && state == IDLE) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[mem_wa] <= mem_wd;
    end
endmodule
